// File: rtl/vproc_result_pack.sv
// Result packer: gathers full or half-width result chunks from an execution unit into whole
// vector register words and hands each finished word to the register-file write arbiter.
module vproc_result_pack #(
  parameter int unsigned VREG_W = 128,
  parameter int unsigned RES_W  = 32
) (
  input  logic                  clk_i,
  input  logic                  async_rst_ni,
  input  logic                  res_valid_i,
  output logic                  res_ready_o,
  input  logic [RES_W-1:0]      res_data_i,
  input  logic [RES_W/8-1:0]    res_be_i,
  input  logic                  res_narrow_i,
  input  logic                  res_last_i,
  input  logic [4:0]            res_vaddr_i,
  output logic                  vreg_wr_valid_o,
  input  logic                  vreg_wr_ready_i,
  output logic [4:0]            vreg_wr_addr_o,
  output logic [VREG_W-1:0]     vreg_wr_data_o,
  output logic [VREG_W/8-1:0]   vreg_wr_be_o
);

  localparam int unsigned NSLOT    = 2 * VREG_W / RES_W;
  localparam int unsigned SLOT_W   = RES_W / 2;
  localparam int unsigned SLOT_B   = SLOT_W / 8;
  localparam int unsigned BE_W     = VREG_W / 8;
  localparam int unsigned RES_BE_W = RES_W / 8;
  localparam int unsigned PTR_W    = $clog2(NSLOT);

  logic [VREG_W-1:0] acc_data;
  logic [BE_W-1:0]   acc_be;
  logic [PTR_W-1:0]  ptr;
  logic              word_narrow;
  logic [4:0]        word_addr;

  logic              eff_narrow;
  logic [4:0]        eff_addr;
  logic [VREG_W-1:0] ins_data;
  logic [BE_W-1:0]   ins_be;
  logic [VREG_W-1:0] merge_data;
  logic [BE_W-1:0]   merge_be;
  logic [PTR_W-1:0]  ptr_nxt;
  logic              fills_last;
  logic              completes;
  logic              accept;
  logic              load;

  // Word shape and destination are taken from the first chunk of a word only.
  // NOTE: every signal gets a default at the top of always_comb so no path leaves it
  // unassigned and no latch is inferred.
  always_comb begin
    eff_narrow = word_narrow;
    eff_addr   = word_addr;
    if (ptr == '0) begin
      eff_narrow = res_narrow_i;
      eff_addr   = res_vaddr_i;
    end

    ins_data   = {{(VREG_W - RES_W){1'b0}}, res_data_i};
    ins_be     = {{(BE_W - RES_BE_W){1'b0}}, res_be_i};
    fills_last = (ptr == PTR_W'(NSLOT - 2));
    ptr_nxt    = ptr + PTR_W'(2);
    if (eff_narrow) begin
      ins_data   = {{(VREG_W - SLOT_W){1'b0}}, res_data_i[SLOT_W-1:0]};
      ins_be     = {{(BE_W - SLOT_B){1'b0}}, res_be_i[SLOT_B-1:0]};
      fills_last = (ptr == PTR_W'(NSLOT - 1));
      ptr_nxt    = ptr + PTR_W'(1);
    end

    // Slots above ptr are always still clear, so OR-ing the shifted chunk is a merge.
    merge_data = acc_data | (ins_data << (int'(ptr) * SLOT_W));
    merge_be   = acc_be   | (ins_be   << (int'(ptr) * SLOT_B));
  end

  assign completes   = fills_last || res_last_i;
  // Only a completing chunk needs the holding stage; it stalls while that stage is blocked.
  assign res_ready_o = !(completes && vreg_wr_valid_o && !vreg_wr_ready_i);
  assign accept      = res_valid_i && res_ready_o;
  assign load        = accept && completes;

  // NOTE: sequential state uses non-blocking assignments so every register samples the
  // pre-edge values, independent of statement order. The accumulator is reset explicitly
  // because partially built words must never leak into a word started after reset.
  always_ff @(posedge clk_i or negedge async_rst_ni) begin
    if (!async_rst_ni) begin
      acc_data    <= '0;
      acc_be      <= '0;
      ptr         <= '0;
      word_narrow <= 1'b0;
      word_addr   <= '0;
    end else if (accept) begin
      if (completes) begin
        acc_data <= '0;
        acc_be   <= '0;
        ptr      <= '0;
      end else begin
        acc_data <= merge_data;
        acc_be   <= merge_be;
        ptr      <= ptr_nxt;
        if (ptr == '0) begin
          word_narrow <= res_narrow_i;
          word_addr   <= res_vaddr_i;
        end
      end
    end
  end

  // One-entry holding stage; reloading on a grant edge keeps valid high without a bubble.
  always_ff @(posedge clk_i or negedge async_rst_ni) begin
    if (!async_rst_ni) begin
      vreg_wr_valid_o <= 1'b0;
      vreg_wr_addr_o  <= '0;
      vreg_wr_data_o  <= '0;
      vreg_wr_be_o    <= '0;
    end else if (load) begin
      vreg_wr_valid_o <= 1'b1;
      vreg_wr_addr_o  <= eff_addr;
      vreg_wr_data_o  <= merge_data;
      vreg_wr_be_o    <= merge_be;
    end else if (vreg_wr_ready_i) begin
      vreg_wr_valid_o <= 1'b0;
    end
  end

endmodule

// File: tb/tb_vproc_result_pack.sv
// Directed bench for vproc_result_pack: full, narrow, early-terminated and masked words,
// write-port backpressure and asynchronous reset in the middle of a word.
module tb_vproc_result_pack;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         res_valid;
  logic         res_ready;
  logic [31:0]  res_data;
  logic [3:0]   res_be;
  logic         res_narrow;
  logic         res_last;
  logic [4:0]   res_vaddr;
  logic         wr_valid;
  logic         wr_ready;
  logic [4:0]   wr_addr;
  logic [127:0] wr_data;
  logic [15:0]  wr_be;

  typedef struct {
    logic [4:0]   addr;
    logic [127:0] data;
    logic [15:0]  be;
    int           cyc;
  } wr_t;

  wr_t q[$];
  int  cyc = 0;
  int  acc_cyc = 0;
  int  n_tests = 0;
  int  n_fail = 0;

  localparam logic [127:0] WORD_A = 128'h0F0E0D0C_0B0A0908_07060504_03020100;
  localparam logic [127:0] WORD_B = 128'h1F1E1D1C_1B1A1918_17161514_13121110;
  localparam logic [127:0] WORD_C = 128'hCAFE0004_CAFE0003_CAFE0002_CAFE0001;

  vproc_result_pack dut (
    .clk_i           (clk),
    .async_rst_ni    (rst_n),
    .res_valid_i     (res_valid),
    .res_ready_o     (res_ready),
    .res_data_i      (res_data),
    .res_be_i        (res_be),
    .res_narrow_i    (res_narrow),
    .res_last_i      (res_last),
    .res_vaddr_i     (res_vaddr),
    .vreg_wr_valid_o (wr_valid),
    .vreg_wr_ready_i (wr_ready),
    .vreg_wr_addr_o  (wr_addr),
    .vreg_wr_data_o  (wr_data),
    .vreg_wr_be_o    (wr_be)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Record every completed write handshake; inputs are stable at the falling edge.
  always @(negedge clk) begin
    if (rst_n && wr_valid && wr_ready) begin
      wr_t w;
      w.addr = wr_addr;
      w.data = wr_data;
      w.be   = wr_be;
      w.cyc  = cyc;
      q.push_back(w);
    end
  end

  // A full-width chunk may never land on an odd slot of a narrow word.
  always @(negedge clk) begin
    if (rst_n && res_valid && res_ready && dut.ptr[0])
      assert (res_narrow) else $error("FAIL illegal_mixed_chunk ptr=%0d", dut.ptr);
  end

  task automatic check(input string tag, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic idle();
    res_valid = 1'b0;
    res_last  = 1'b0;
  endtask

  // Present one chunk (caller sits just after a rising edge) and wait until it is taken.
  task automatic send(input logic [31:0] d, input logic [3:0] be, input logic nar,
                      input logic last, input logic [4:0] a);
    int k = 0;
    res_valid  = 1'b1;
    res_data   = d;
    res_be     = be;
    res_narrow = nar;
    res_last   = last;
    res_vaddr  = a;
    #1;
    while (!res_ready && k < 50) begin
      @(posedge clk);
      #2;
      k++;
    end
    if (k >= 50) check("send_timeout", 1, 0);
    @(posedge clk);
    #1;
    acc_cyc = cyc;
  endtask

  task automatic send_word(input logic [127:0] w, input logic [4:0] a);
    for (int i = 0; i < 4; i++) send(w[32*i +: 32], 4'hF, 1'b0, 1'b0, a);
  endtask

  initial begin
    rst_n = 1'b0;
    wr_ready = 1'b0;
    res_valid = 1'b0; res_data = '0; res_be = '0;
    res_narrow = 1'b0; res_last = 1'b0; res_vaddr = '0;
    #2;
    check("rst_wr_valid", wr_valid, 0);
    check("rst_wr_addr", wr_addr, 0);
    check("rst_wr_data", wr_data, 0);
    check("rst_wr_be", wr_be, 0);
    check("rst_res_ready", res_ready, 1);
    #10 rst_n = 1'b1;
    tick(1);

    // T1: four normal chunks make one full word.
    wr_ready = 1'b1;
    q.delete();
    send_word(WORD_A, 5'd5);
    idle();
    tick(4);
    check("t1_count", q.size(), 1);
    if (q.size() >= 1) begin
      check("t1_addr", q[0].addr, 5);
      check("t1_data", q[0].data, WORD_A);
      check("t1_be", q[0].be, 16'hFFFF);
      check("t1_latency", q[0].cyc, acc_cyc);
    end

    // T2: eight narrow chunks; upper halves of data/BE must be ignored.
    q.delete();
    for (int i = 0; i < 8; i++)
      send({16'hDEAD, WORD_A[16*i +: 16]}, 4'hF, 1'b1, 1'b0, 5'd6);
    idle();
    tick(4);
    check("t2_count", q.size(), 1);
    if (q.size() >= 1) begin
      check("t2_addr", q[0].addr, 6);
      check("t2_data", q[0].data, WORD_A);
      check("t2_be", q[0].be, 16'hFFFF);
      check("t2_latency", q[0].cyc, acc_cyc);
    end

    // T3: early terminate after two chunks.
    q.delete();
    send(32'h03020100, 4'hF, 1'b0, 1'b0, 5'd3);
    send(32'h07060504, 4'hF, 1'b0, 1'b1, 5'd3);
    idle();
    tick(4);
    check("t3_count", q.size(), 1);
    if (q.size() >= 1) begin
      check("t3_addr", q[0].addr, 3);
      check("t3_data", q[0].data, 128'h07060504_03020100);
      check("t3_be", q[0].be, 16'h00FF);
    end

    // T4: second word completes while the first is still blocked on the write port.
    q.delete();
    wr_ready = 1'b0;
    send_word(WORD_A, 5'd1);
    for (int i = 0; i < 3; i++) send(WORD_B[32*i +: 32], 4'hF, 1'b0, 1'b0, 5'd2);
    res_valid = 1'b1; res_data = WORD_B[127:96]; res_be = 4'hF;
    res_narrow = 1'b0; res_last = 1'b0; res_vaddr = 5'd2;
    #1;
    check("t4_stall_ready", res_ready, 0);
    check("t4_hold_valid", wr_valid, 1);
    check("t4_hold_data", wr_data, WORD_A);
    tick(2);
    check("t4_stall_ready2", res_ready, 0);
    check("t4_hold_data2", wr_data, WORD_A);
    check("t4_hold_addr", wr_addr, 1);
    wr_ready = 1'b1;
    #1;
    check("t4_ready_back", res_ready, 1);
    tick(1);
    idle();
    check("t4_reload_valid", wr_valid, 1);
    check("t4_reload_data", wr_data, WORD_B);
    check("t4_reload_addr", wr_addr, 2);
    tick(4);
    check("t4_count", q.size(), 2);
    if (q.size() >= 2) begin
      check("t4_w1_data", q[0].data, WORD_A);
      check("t4_w2_data", q[1].data, WORD_B);
      check("t4_w2_addr", q[1].addr, 2);
    end
    check("t4_drained", wr_valid, 0);

    // T5: byte-granular masks.
    q.delete();
    send(32'h11111111, 4'h5, 1'b0, 1'b0, 5'd4);
    send(32'h22222222, 4'hA, 1'b0, 1'b0, 5'd4);
    send(32'h33333333, 4'h0, 1'b0, 1'b0, 5'd4);
    send(32'h44444444, 4'hF, 1'b0, 1'b0, 5'd4);
    idle();
    tick(4);
    check("t5_count", q.size(), 1);
    if (q.size() >= 1) check("t5_be", q[0].be, 16'hF0A5);

    // T6: reset with a write pending and a partial word in the accumulator.
    q.delete();
    wr_ready = 1'b0;
    send_word(WORD_B, 5'd7);
    send(32'hAAAA0001, 4'hF, 1'b0, 1'b0, 5'd8);
    send(32'hAAAA0002, 4'hF, 1'b0, 1'b0, 5'd8);
    idle();
    #2 rst_n = 1'b0;
    #1;
    check("t6_rst_valid", wr_valid, 0);
    check("t6_rst_be", wr_be, 0);
    check("t6_rst_data", wr_data, 0);
    @(negedge clk);
    rst_n = 1'b1;
    q.delete();
    wr_ready = 1'b1;
    tick(1);
    send_word(WORD_C, 5'd9);
    idle();
    tick(4);
    check("t6_count", q.size(), 1);
    if (q.size() >= 1) begin
      check("t6_addr", q[0].addr, 9);
      check("t6_data", q[0].data, WORD_C);
      check("t6_be", q[0].be, 16'hFFFF);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
